// File: rtl/uart_tx_fsm.sv
// UART transmitter: control FSM plus shift register, one byte per frame, LSB first.
// Frame: start bit (0), 8 data bits, optional parity bit, STOP_BITS stop bits (1).
// Bit timing is taken from an external oversample tick shared with the RX path.
// Define UART_TX_PARITY_EN to include the parity state (odd/even chosen by PARITY_ODD).
module uart_tx_fsm #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned STOP_BITS  = 1
`ifdef UART_TX_PARITY_EN
  ,
  parameter int unsigned PARITY_ODD = 0
`endif
) (
  input  logic       clk,
  input  logic       areset_n,
  input  logic       en,
  input  logic       reset,
  input  logic       tick,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned NCNT_W = 3;

  localparam logic [CNT_W-1:0]  S_LAST      = CNT_W'(OVERSAMPLE - 1);
  localparam logic [NCNT_W-1:0] N_LAST_DATA = NCNT_W'(DATA_W - 1);
  localparam logic [NCNT_W-1:0] N_LAST_STOP = NCNT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    s_cnt_q, s_cnt_d;
  logic [NCNT_W-1:0]   n_cnt_q, n_cnt_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef UART_TX_PARITY_EN
  logic                par_q, par_d;
`endif
  logic                s_last_c;

  // Last oversample tick of the current bit period.
  assign s_last_c = tick && (s_cnt_q == S_LAST);

  // Next-state, counter, shift register and line computation.
  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (en) begin
      if (reset) begin
        state_d = S_IDLE;
        s_cnt_d = '0;
        n_cnt_d = '0;
        shreg_d = '0;
        tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
        par_d   = 1'b0;
`endif
      end else begin
        case (state_q)
          S_IDLE: begin
            tx_d = 1'b1;
            if (tx_start) begin
              shreg_d = tx_data;
              s_cnt_d = '0;
              tx_d    = 1'b0;
              state_d = S_START;
`ifdef UART_TX_PARITY_EN
              par_d   = (^tx_data) ^ 1'(PARITY_ODD);
`endif
            end
          end
          S_START: begin
            tx_d = 1'b0;
            if (s_last_c) begin
              s_cnt_d = '0;
              n_cnt_d = '0;
              tx_d    = shreg_q[0];
              state_d = S_DATA;
            end else if (tick) begin
              s_cnt_d = s_cnt_q + CNT_W'(1);
            end
          end
          S_DATA: begin
            if (s_last_c) begin
              s_cnt_d = '0;
              shreg_d = shreg_q >> 1;
              if (n_cnt_q == N_LAST_DATA) begin
                n_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                tx_d    = par_q;
                state_d = S_PARITY;
`else
                tx_d    = 1'b1;
                state_d = S_STOP;
`endif
              end else begin
                n_cnt_d = n_cnt_q + NCNT_W'(1);
                tx_d    = shreg_q[1];
              end
            end else if (tick) begin
              s_cnt_d = s_cnt_q + CNT_W'(1);
            end
          end
`ifdef UART_TX_PARITY_EN
          S_PARITY: begin
            if (s_last_c) begin
              s_cnt_d = '0;
              n_cnt_d = '0;
              tx_d    = 1'b1;
              state_d = S_STOP;
            end else if (tick) begin
              s_cnt_d = s_cnt_q + CNT_W'(1);
            end
          end
`endif
          S_STOP: begin
            tx_d = 1'b1;
            if (s_last_c) begin
              s_cnt_d = '0;
              if (n_cnt_q == N_LAST_STOP) begin
                n_cnt_d = '0;
                state_d = S_DONE;
              end else begin
                n_cnt_d = n_cnt_q + NCNT_W'(1);
              end
            end else if (tick) begin
              s_cnt_d = s_cnt_q + CNT_W'(1);
            end
          end
          S_DONE: begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
          default: begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
          end
        endcase
      end
    end
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and registered outputs; async reset returns the line to idle immediately.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= S_IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Testbench for uart_tx_fsm: directed frames with a line-decoding scoreboard monitor.
// Frame layout follows UART_TX_PARITY_EN when defined (even parity, one stop bit).
module tb_uart_tx_fsm;

  localparam int unsigned OS = 16;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       areset_n;
  logic       en;
  logic       reset;
  logic       tick;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int tick_period = 1;
  int tick_div = 0;
  logic [7:0] exp_q[$];

  uart_tx_fsm dut (
    .clk      (clk),
    .areset_n (areset_n),
    .en       (en),
    .reset    (reset),
    .tick     (tick),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx       (tx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // Free-running oversample tick, one clk wide every tick_period cycles.
  always @(posedge clk) tick_div <= (tick_div >= tick_period - 1) ? 0 : tick_div + 1;
  assign tick = (tick_div == 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input bit push);
    tx_data  = d;
    tx_start = 1'b1;
    if (push) exp_q.push_back(d);
    step();
    tx_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < budget) begin
      step();
      cyc++;
    end
    if (done !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: done not seen within %0d cycles", name, budget);
    end
  endtask

  // Monitor: decodes frames off the line by counting enabled ticks, compares against queue.
  initial begin : monitor
    logic       in_frame;
    logic       done_prev;
    int         k;
    int         b;
    logic [7:0] byte_v;
    logic [7:0] exp_b;
    in_frame  = 1'b0;
    done_prev = 1'b0;
    k         = 0;
    byte_v    = '0;
    forever begin
      @(negedge clk);
      if (done === 1'b1 && !done_prev) done_cnt++;
      done_prev = (done === 1'b1);
      if (areset_n !== 1'b1 || (en === 1'b1 && reset === 1'b1)) begin
        in_frame = 1'b0;
      end else begin
        if (!in_frame && tx === 1'b0) begin
          in_frame = 1'b1;
          k        = 0;
          byte_v   = '0;
        end
        if (in_frame && tick && en) begin
          k++;
          if ((k % OS) == OS / 2) begin
            b = k / OS;
            if (b == 0) begin
              check("mon_start_bit", tx, 0);
            end else if (b <= 8) begin
              byte_v[b-1] = tx;
`ifdef UART_TX_PARITY_EN
            end else if (b == 9) begin
              check("mon_parity_bit", tx, ^byte_v);
`endif
            end else begin
              check("mon_stop_bit", tx, 1);
              in_frame = 1'b0;
              if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL mon_unexpected_frame: got byte 0x%0h, expected no frame", byte_v);
              end else begin
                exp_b = exp_q.pop_front();
                check("mon_frame_byte", byte_v, exp_b);
              end
            end
          end
        end
      end
    end
  end

  // Stimulus: directed scenarios with hand-derived timing.
  initial begin : stim
    logic [7:0] b;
    logic       e;
    logic       ok;
    logic       frz;
    int         c;
    int         d0;
    int         low;
    int         done_at;

    areset_n    = 1'b0;
    en          = 1'b1;
    reset       = 1'b0;
    tx_start    = 1'b0;
    tx_data     = '0;
    tick_period = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    areset_n = 1'b1;
    step();
    step();
    check("idle_tx", tx, 1);
    check("idle_busy", busy, 0);

    // 1: 0xA5, tick every cycle, cycle-exact line/busy/done
    b       = 8'hA5;
    done_at = 161 + 16 * P;
    send(b, 1'b1);
    for (int k = 1; k <= 164; k++) begin
      if (k <= 16)                e = 1'b0;
      else if (k <= 144)          e = b[(k - 17) / 16];
      else if (k <= 144 + 16 * P) e = ^b;
      else                        e = 1'b1;
      check($sformatf("t1_tx@%0d", k), tx, e);
      check($sformatf("t1_busy@%0d", k), busy, k <= done_at);
      check($sformatf("t1_done@%0d", k), done, k == done_at);
      step();
    end

    // 2: tick every 4th cycle, 0x00, start coincident with a tick
    tick_period = 4;
    d0 = done_cnt;
    while (tick !== 1'b1) step();
    send(8'h00, 1'b1);
    low = 0;
    while (tx === 1'b0 && low < 2000) begin
      low++;
      step();
    end
    check("t2_low_cycles", low, 576 + 64 * P);
    wait_done("t2", 4000, c);
    step();
    check("t2_done_count", done_cnt - d0, 1);
    tick_period = 1;
    repeat (4) step();

    // 3: tx_start with other data during bit 3 is ignored
    d0 = done_cnt;
    send(8'h3C, 1'b1);
    repeat (69) step();
    tx_data  = 8'hFF;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    check("t3_busy_hold", busy, 1);
    wait_done("t3", 400, c);
    step();
    check("t3_done_count", done_cnt - d0, 1);
    ok = 1'b1;
    repeat (40) begin
      if (tx !== 1'b1 || busy !== 1'b0) ok = 1'b0;
      step();
    end
    check("t3_no_second_frame", ok, 1);

    // 4: sync reset during data bit 5 aborts, then 0xFF goes out normally
    d0 = done_cnt;
    send(8'h55, 1'b0);
    repeat (100) step();
    reset = 1'b1;
    step();
    check("t4_tx_after_reset", tx, 1);
    check("t4_busy_after_reset", busy, 0);
    check("t4_done_after_reset", done, 0);
    reset = 1'b0;
    repeat (200) step();
    check("t4_no_done", done_cnt - d0, 0);
    d0 = done_cnt;
    send(8'hFF, 1'b1);
    wait_done("t4", 400, c);
    step();
    check("t4_done_count", done_cnt - d0, 1);

    // 5: en low for 50 cycles mid-data freezes everything and stretches the frame
    send(8'h96, 1'b1);
    repeat (54) step();
    en  = 1'b0;
    frz = tx;
    ok  = 1'b1;
    repeat (50) begin
      step();
      if (tx !== frz || busy !== 1'b1) ok = 1'b0;
    end
    check("t5_frozen", ok, 1);
    en = 1'b1;
    wait_done("t5", 400, c);
    check("t5_frame_len", 105 + c, 211 + 16 * P);
    step();

    // 6: 0x07 (odd number of ones)
    send(8'h07, 1'b1);
    wait_done("t6", 400, c);
    step();

    // 7: async reset mid-frame forces the line high before the next edge
    d0 = done_cnt;
    send(8'hC3, 1'b0);
    repeat (40) step();
    areset_n = 1'b0;
    #1;
    check("t7_tx_async", tx, 1);
    check("t7_busy_async", busy, 0);
    step();
    areset_n = 1'b1;
    repeat (200) step();
    check("t7_no_done", done_cnt - d0, 0);

    // 8: tx_start held through DONE restarts on the first IDLE cycle; mid-frame data change
    d0       = done_cnt;
    tx_data  = 8'h81;
    tx_start = 1'b1;
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h00);
    step();
    repeat (49) step();
    tx_data = 8'h00;
    repeat (111 + 16 * P) step();
    check("t8_done_first", done, 1);
    step();
    check("t8_idle_busy", busy, 0);
    check("t8_idle_tx", tx, 1);
    step();
    check("t8_restart_busy", busy, 1);
    check("t8_restart_tx", tx, 0);
    tx_start = 1'b0;
    wait_done("t8", 400, c);
    step();
    check("t8_done_count", done_cnt - d0, 2);

    repeat (4) step();
    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
